// File: rtl/div_unit.sv
// Sequential signed 32-bit divider: restoring shift-subtract on magnitudes,
// one quotient bit per cycle, with signs fixed up in a final write cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             divzero
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;
  localparam int CW = $clog2(WIDTH) + 1;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [2*WIDTH-1:0] pair_q, pair_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               divzero_q, divzero_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   shifted, diff;
  logic             ge;
  logic [WIDTH-1:0] quo, rem;

  // Two's-complement negation wraps 0x80000000 onto itself, which is the
  // correct unsigned magnitude.
  assign abs_a = a[WIDTH-1] ? ({WIDTH{1'b0}} - a) : a;
  assign abs_b = b[WIDTH-1] ? ({WIDTH{1'b0}} - b) : b;

  assign shifted = pair_q[2*WIDTH-1:WIDTH-1];
  assign diff    = shifted - {1'b0, dvs_q};
  assign ge      = ~diff[WIDTH];
  assign quo     = pair_q[WIDTH-1:0];
  assign rem     = pair_q[2*WIDTH-1:WIDTH];

  always_comb begin
    // NOTE: every _d gets a default first so no path can infer a latch.
    state_d   = state_q;
    count_d   = count_q;
    dvs_d     = dvs_q;
    pair_d    = pair_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (div) begin
          if (b == '0) begin
            divzero_d = 1'b1;
          end else begin
            dvs_d     = abs_b;
            pair_d    = {{WIDTH{1'b0}}, abs_a};
            neg_rem_d = a[WIDTH-1];
            neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
            count_d   = CW'(WIDTH);
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        if (count_q != '0) begin
          pair_d  = {(ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]),
                     pair_q[WIDTH-2:0], ge};
          count_d = count_q - 1'b1;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        lo_d    = neg_quo_q ? ({WIDTH{1'b0}} - quo) : quo;
        hi_d    = neg_rem_q ? ({WIDTH{1'b0}} - rem) : rem;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      dvs_q     <= '0;
      pair_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      dvs_q     <= dvs_d;
      pair_q    <= pair_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign divzero = divzero_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, random operands
// against an arithmetic reference, and hand-written abort/ignore sequences.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        div = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] hi, lo;
  logic        busy, done, divzero;

  int tests = 0;
  int fails = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .div(div), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .divzero(divzero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Truncating signed division; the lone overflow case wraps to the dividend.
  function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
      q = ma;
      r = '0;
    end else begin
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
  endfunction

  task automatic do_div(input logic [31:0] ta, input logic [31:0] tb_b, input bit sync,
                        output logic [31:0] rhi, output logic [31:0] rlo, output int lat,
                        output bit busy_ok, output bit held_ok, output bit dz_seen,
                        output bit done_one);
    logic [31:0] h0, l0;
    if (sync) @(negedge clk);
    a = ta; b = tb_b; div = 1'b1;
    h0 = hi; l0 = lo;
    @(posedge clk);
    @(negedge clk);
    div = 1'b0;
    busy_ok = busy; held_ok = 1'b1; dz_seen = divzero; lat = -1;
    rhi = hi; rlo = lo; done_one = 1'b0;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (divzero) dz_seen = 1'b1;
      if (done) begin
        lat = k; rhi = hi; rlo = lo;
      end else begin
        if (!busy) busy_ok = 1'b0;
        if (hi !== h0 || lo !== l0) held_ok = 1'b0;
      end
    end
    if (lat >= 0) begin
      @(posedge clk);
      @(negedge clk);
      done_one = !done && !busy && hi === rhi && lo === rlo;
    end
  endtask

  vec_t vecs[6];

  initial begin
    logic [31:0] rhi, rlo, eq, er, ra, rb;
    int lat, ndone, first_k;
    bit busy_ok, held_ok, dz_seen, done_one, dz_ok;

    vecs[0] = '{32'd7,         32'd2,         32'h0000_0003, 32'h0000_0001};
    vecs[1] = '{32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vecs[2] = '{32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001};
    vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
    vecs[4] = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_flags", {29'd0, busy, done, divzero}, 32'h0);
    reset = 1'b0;

    // Directed vectors, including latency and flag behaviour
    foreach (vecs[i]) begin
      do_div(vecs[i].a, vecs[i].b, 1'b1, rhi, rlo, lat, busy_ok, held_ok, dz_seen, done_one);
      check($sformatf("vec%0d_lo", i), rlo, vecs[i].lo);
      check($sformatf("vec%0d_hi", i), rhi, vecs[i].hi);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd34);
      check($sformatf("vec%0d_busy", i), {31'd0, busy_ok}, 32'd1);
      check($sformatf("vec%0d_hold", i), {31'd0, held_ok}, 32'd1);
      check($sformatf("vec%0d_nodz", i), {31'd0, dz_seen}, 32'd0);
      check($sformatf("vec%0d_done_pulse", i), {31'd0, done_one}, 32'd1);
    end

    // Divide by zero after hi/lo were loaded by a previous divide
    do_div(32'd7, 32'd2, 1'b1, rhi, rlo, lat, busy_ok, held_ok, dz_seen, done_one);
    @(negedge clk);
    a = 32'd5; b = 32'd0; div = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div = 1'b0;
    check("dz_pulse", {29'd0, divzero, busy, done}, 32'b100);
    ndone = 0; dz_ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) ndone++;
      if (divzero) dz_ok = 1'b0;
    end
    check("dz_single_cycle", {31'd0, dz_ok}, 32'd1);
    check("dz_no_activity", 32'(ndone), 32'd0);
    check("dz_hi_kept", hi, 32'h1);
    check("dz_lo_kept", lo, 32'h3);

    // Reset mid-run aborts, then a divide in the first cycle after reset
    @(negedge clk);
    a = 32'd100; b = 32'd7; div = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div = 1'b0;
    repeat (9) begin @(posedge clk); @(negedge clk); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    check("abort_flags", {29'd0, busy, done, divzero}, 32'h0);
    reset = 1'b0;
    do_div(32'd9, 32'd3, 1'b0, rhi, rlo, lat, busy_ok, held_ok, dz_seen, done_one);
    check("post_reset_lo", rlo, 32'd3);
    check("post_reset_hi", rhi, 32'd0);
    check("post_reset_latency", 32'(lat), 32'd34);

    // Re-issued div and operand changes during RUN are ignored
    @(negedge clk);
    a = 32'd100; b = 32'd7; div = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div = 1'b0;
    ndone = 0; first_k = -1; rhi = '0; rlo = '0;
    for (int k = 1; k <= 50; k++) begin
      if (k == 5)  begin div = 1'b1; a = 32'd1; b = 32'd1; end
      if (k == 6)  div = 1'b0;
      if (k == 10) begin a = 32'd555; b = 32'd0; end
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first_k < 0) begin first_k = k; rhi = hi; rlo = lo; end
      end
    end
    check("ignore_done_count", 32'(ndone), 32'd1);
    check("ignore_latency", 32'(first_k), 32'd34);
    check("ignore_lo", rlo, 32'd14);
    check("ignore_hi", rhi, 32'd2);

    // Random operands against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(1, 20))
                                                      : -32'($urandom_range(1, 20));
      if (i % 5 == 1) ra = 32'h8000_0000;
      if (rb == '0) rb = 32'd1;
      model(ra, rb, eq, er);
      do_div(ra, rb, 1'b1, rhi, rlo, lat, busy_ok, held_ok, dz_seen, done_one);
      check($sformatf("rand%0d_lo(%h/%h)", i, ra, rb), rlo, eq);
      check($sformatf("rand%0d_hi(%h/%h)", i, ra, rb), rhi, er);
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'd34);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
